// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the memory responder
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous word RAM with registered read
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - req/ack memory responder with wait states; MEM_RESPONDER_ALIGN_CHECK_EN enables misalignment errors
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Req,
  input  logic              We,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] WData,
  output logic [WORD_W-1:0] RData,
  output logic              Ack,
  output logic              Err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  cnt, cnt_nxt;
  logic              latch, access;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              ack_q, err_q, load_q;
  logic              acc_we, acc_err;
  logic [WORD_W-1:0] acc_addr, acc_wdata, arr_rdata;
  logic [29:0]       acc_widx;

  // With zero latency the access happens on the accepting edge, so use live inputs.
  assign acc_we    = (state == IDLE) ? We    : we_q;
  assign acc_addr  = (state == IDLE) ? Addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? WData : wdata_q;
  assign acc_widx  = acc_addr[31:2];
  assign acc_err   = ({2'b00, acc_widx} >= 32'(DEPTH)) |
                     (ALIGN_EN & (acc_addr[1:0] != 2'b00));

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Req) begin
          latch   = 1'b1;
          cnt_nxt = LAT;
          if (LAT == '0) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == LAT_W'(1)) begin
          state_nxt = RESP;
          access    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      if (latch) begin
        we_q    <= We;
        addr_q  <= Addr;
        wdata_q <= WData;
      end
      ack_q  <= access;
      err_q  <= access & acc_err;
      load_q <= access & ~acc_we & ~acc_err;
    end
  end

  mem_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .en    (access & ~acc_err),
    .we    (acc_we),
    .addr  (acc_widx[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign Ack   = ack_q;
  assign Err   = err_q;
  assign RData = load_q ? arr_rdata : '0;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle MIPS datapath: a unified, word-addressed instruction/data memory that services the controller's fetch, load and store requests over a req/ack handshake with programmable wait states. It replaces the zero-wait combinational memory so the controller FSM can be exercised against realistic access latency. One transaction is in flight at a time. Errors are reported for out-of-range and, optionally, misaligned addresses.

## Interface
- Parameters:
- `DEPTH`, default 256: memory size in 32-bit words; must be a power of two.
- `LATENCY`, default 2: wait-state cycles per access; legal range 0–15.
- Ports:
- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `ResetN`, input, 1: asynchronous, active-low reset.
- `Req`, input, 1: access request; held high with stable `We`/`Addr`/`WData` until `Ack`.
- `We`, input, 1: 1 = store, 0 = fetch/load.
- `Addr`, input, 32: byte address; the word index is `Addr[31:2]`.
- `WData`, input, 32: store data.
- `RData`, output, 32: load data; valid only while `Ack` = 1.
- `Ack`, output, 1: one-cycle completion pulse.
- `Err`, output, 1: qualifies `Ack`; the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
- With `Req` = 1 at an edge: latch `We`/`Addr`/`WData`, load counter with `LATENCY`.
- Go to RESP if `LATENCY` = 0, else to WAIT.
- With `Req` = 0: stay in IDLE.
- WAIT:
- Decrement the counter each edge.
- On the edge where counter = 1, go to RESP and perform the array access.
- RESP:
- `Ack` = 1 for exactly one cycle; `Req` is ignored.
- Always returns to IDLE.
- Array access happens on the edge entering RESP:
- Store: write latched `WData` to word `Addr[31:2]`; `RData` = 0.
- Load: register the array word into `RData`.
- Error conditions:
- Out of range: `Addr[31:2]` ≥ `DEPTH` gives `Err` = 1, write suppressed, `RData` = 0.
- Misaligned: see Configuration.
- `Err` uses the same timing as `Ack`; `Err` = 0 whenever `Ack` = 0.
- Back-to-back requests: if `Req` is still high in the IDLE cycle after RESP, a new transaction starts. The requester must drop `Req` on seeing `Ack` unless it intends a new access.
- Reset:
- Outputs: `Ack` = 0, `Err` = 0, `RData` = 0.
- State: IDLE, counter = 0.
- Memory contents are not reset.
- Reset mid-transaction aborts the access: no write occurs and no `Ack` is issued.

## Timing
- Let E0 be the edge where `Req` is sampled in IDLE.
- The array access occurs at edge E`LATENCY`.
- `Ack` is high from E`LATENCY` to E`LATENCY`+1.
- The requester samples `Ack` at E`LATENCY`+1.
- Throughput is one access per `LATENCY`+2 cycles with back-to-back requests.
- `LATENCY` = 0: `Ack` is high in the cycle right after E0, and WAIT is never entered.
- Output registering:
- `RData`, `Ack` and `Err` are registered; no combinational path from inputs.
- Changes on `Addr`/`WData` after E0 have no effect.
- Counter width is 4 bits. The counter never underflows: WAIT exits at count 1.

## Configuration
- Macro: `MEM_RESPONDER_ALIGN_CHECK_EN`.
- Defined: `Addr[1:0]` ≠ 0 is rejected.
- `Err` = 1 with `Ack`; write suppressed; `RData` = 0.
- Full `LATENCY` is still observed.
- Undefined: `Addr[1:0]` is ignored, and only range errors exist.

## Structure
- Shared package `mem_pkg` holds:
- the FSM state enum (`IDLE`, `WAIT`, `RESP`);
- `WORD_W` = 32;
- `LAT_W` = 4.
- Sub-module `mem_array`:
- single-port synchronous RAM, `DEPTH` × 32;
- write enable, registered read;
- holds no handshake logic.
- `mem_responder` owns the FSM, the wait counter and the range/alignment checks.

## Test plan
- **Basic store then load.** `LATENCY` = 2. Store 0xDEADBEEF to 0x10, then load 0x10.
  Required: each `Ack` arrives 2 edges after acceptance; the load returns `RData` = 0xDEADBEEF with `Err` = 0.
- **Zero latency.** `LATENCY` = 0. Load from 0x0, preloaded with 0x20080005.
  Required: `Ack` and `RData` = 0x20080005 in the cycle after E0; WAIT never visited.
- **Out of range.** `DEPTH` = 256. Store to 0x400, then load 0x0.
  Required: `Ack` with `Err` = 1; word 0 unchanged.
- **Misaligned access.** With `MEM_RESPONDER_ALIGN_CHECK_EN`: store to 0x13 gives `Err` = 1 and word 4 unchanged. Without it: the same store writes word 4 with `Err` = 0.
- **Reset mid-transaction.** Store 0x12345678 to 0x20 with `LATENCY` = 3; pulse `ResetN` low during WAIT.
  Required: no `Ack`; word 8 keeps its old value; all outputs 0; a later load of 0x20 returns the old value.
- **Back-to-back.** Hold `Req` high across three loads.
  Required: exactly one `Ack` per `LATENCY`+2 cycles; `Req` is not sampled during RESP.
